// File: rtl/gobou_layer_seq_pkg.sv
// Shared types and sizes for the gobou layer sequencer: per-layer parameter
// record, FSM state encoding and the layer-count clamp helper.
package gobou_layer_seq_pkg;

   localparam int MEMSIZE        = 12;
   localparam int GOBOU_NETSIZE  = 14;
   localparam int LWIDTH         = 10;
   localparam int MAX_LAYERS     = 16;
   localparam int LAYERLOG       = 4;
   localparam int GOBOU_LAYERLOG = LAYERLOG;
   localparam int ACK_TIMEOUT    = 8;
   localparam int TOUT_W         = 4;

   typedef struct packed {
      logic [MEMSIZE-1:0]       in_offset;
      logic [MEMSIZE-1:0]       out_offset;
      logic [GOBOU_NETSIZE-1:0] net_offset;
      logic [LWIDTH-1:0]        total_out;
      logic [LWIDTH-1:0]        total_in;
      logic                     bias_en;
      logic                     relu_en;
   } layer_param_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_REQ  = 3'd2,
      S_RUN  = 3'd3,
      S_GAP  = 3'd4,
      S_DONE = 3'd5
   } seq_state_t;

   function automatic logic [LAYERLOG:0] clamp_layers(input logic [LAYERLOG:0] n);
      return (n > (LAYERLOG+1)'(MAX_LAYERS)) ? (LAYERLOG+1)'(MAX_LAYERS) : n;
   endfunction

endpackage

// File: rtl/gobou_layer_table.sv
// Host-programmed per-layer parameter table: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module gobou_layer_table
   import gobou_layer_seq_pkg::*;
(
   input  logic                clk,
   input  logic                we,
   input  logic [LAYERLOG-1:0] waddr,
   input  layer_param_t        wdata,
   input  logic [LAYERLOG-1:0] raddr,
   output layer_param_t        rdata
);

   layer_param_t mem [MAX_LAYERS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/gobou_layer_seq.sv
// Sequences a programmed list of layers onto the gobou core controller, one
// req/ack handshake per layer, and pulses done after the last layer.
module gobou_layer_seq
   import gobou_layer_seq_pkg::*;
(
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     prog_we,
   input  logic [LAYERLOG-1:0]      prog_addr,
   input  layer_param_t             prog_param,
   input  logic [LAYERLOG:0]        num_layers,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [LAYERLOG-1:0]      layer_idx,
   output logic                     req,
   input  logic                     ack,
   output logic [MEMSIZE-1:0]       in_offset,
   output logic [MEMSIZE-1:0]       out_offset,
   output logic [GOBOU_NETSIZE-1:0] net_offset,
   output logic [LWIDTH-1:0]        total_out,
   output logic [LWIDTH-1:0]        total_in,
   output logic                     bias_en,
   output logic                     relu_en,
   output seq_state_t               fsm_state
);

   // Handshake: req is a level; its rising edge launches a layer. The core
   // answers by dropping ack while the layer runs and raising it when idle.
   // Parameters are stable one cycle before req rises and until the next load.

   seq_state_t          state;
   logic [LAYERLOG:0]   n_lay;
   logic [LAYERLOG-1:0] idx;
   logic [TOUT_W-1:0]   tcnt;
   layer_param_t        prm;
   layer_param_t        rd_param;
   logic                tab_we;

   // The table is frozen for the whole run; only idle-time writes land.
   assign tab_we = prog_we && (state == S_IDLE);

   gobou_layer_table u_table (
      .clk   (clk),
      .we    (tab_we),
      .waddr (prog_addr),
      .wdata (prog_param),
      .raddr (idx),
      .rdata (rd_param)
   );

   always_ff @(posedge clk) begin
      if (xrst) begin
         state <= S_IDLE;
         n_lay <= '0;
         idx   <= '0;
         tcnt  <= '0;
         prm   <= '0;
         req   <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_lay <= clamp_layers(num_layers);
                  err   <= 1'b0;
                  idx   <= '0;
                  state <= (num_layers == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               prm   <= rd_param;
               tcnt  <= '0;
               state <= S_REQ;
            end
            S_REQ: begin
               // ack only counts once our req is actually visible to the core
               if (req && !ack) begin
                  state <= S_RUN;
               end else if (tcnt == TOUT_W'(ACK_TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  req   <= 1'b0;
                  state <= S_DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
                  req  <= 1'b1;
               end
            end
            S_RUN: begin
               if (ack) begin
                  req   <= 1'b0;
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               if (({1'b0, idx} + 1'b1) < n_lay) begin
                  idx   <= idx + 1'b1;
                  state <= S_LOAD;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy       = (state != S_IDLE);
   assign layer_idx  = idx;
   assign fsm_state  = state;
   assign in_offset  = prm.in_offset;
   assign out_offset = prm.out_offset;
   assign net_offset = prm.net_offset;
   assign total_out  = prm.total_out;
   assign total_in   = prm.total_in;
   assign bias_en    = prm.bias_en;
   assign relu_en    = prm.relu_en;

endmodule

// File: tb/tb_gobou_layer_seq.sv
// Bench for gobou_layer_seq: behavioural core model, table model and an
// expected queue of (layer index, parameters) per req launch.
module tb_gobou_layer_seq;
   import gobou_layer_seq_pkg::*;

   localparam int W = LAYERLOG + $bits(layer_param_t);

   logic                     clk = 1'b0;
   logic                     xrst;
   logic                     prog_we;
   logic [LAYERLOG-1:0]      prog_addr;
   layer_param_t             prog_param;
   logic [LAYERLOG:0]        num_layers;
   logic                     start;
   logic                     busy, done, err, req, ack;
   logic [LAYERLOG-1:0]      layer_idx;
   logic [MEMSIZE-1:0]       in_offset, out_offset;
   logic [GOBOU_NETSIZE-1:0] net_offset;
   logic [LWIDTH-1:0]        total_out, total_in;
   logic                     bias_en, relu_en;
   seq_state_t               fsm_state;

   gobou_layer_seq dut (
      .clk(clk), .xrst(xrst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_param(prog_param), .num_layers(num_layers), .start(start),
      .busy(busy), .done(done), .err(err), .layer_idx(layer_idx),
      .req(req), .ack(ack), .in_offset(in_offset), .out_offset(out_offset),
      .net_offset(net_offset), .total_out(total_out), .total_in(total_in),
      .bias_en(bias_en), .relu_en(relu_en), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   layer_param_t model_tab [MAX_LAYERS];
   logic [W-1:0] exp_q[$];
   int rises = 0;
   int dones = 0;
   bit mon_en = 1'b1;
   bit core_stuck = 1'b0;
   int run_len = 3;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic layer_param_t rand_param();
      layer_param_t p;
      p.in_offset  = MEMSIZE'($urandom);
      p.out_offset = MEMSIZE'($urandom);
      p.net_offset = GOBOU_NETSIZE'($urandom);
      p.total_out  = LWIDTH'($urandom);
      p.total_in   = LWIDTH'($urandom);
      p.bias_en    = 1'($urandom);
      p.relu_en    = 1'($urandom);
      return p;
   endfunction

   function automatic logic [W-1:0] observed();
      layer_param_t p;
      p.in_offset  = in_offset;
      p.out_offset = out_offset;
      p.net_offset = net_offset;
      p.total_out  = total_out;
      p.total_in   = total_in;
      p.bias_en    = bias_en;
      p.relu_en    = relu_en;
      return {layer_idx, p};
   endfunction

   // core model: ack drops one cycle after a req rise, returns after run_len
   initial begin
      bit req_d;
      req_d = 1'b0;
      ack = 1'b1;
      forever begin
         @(negedge clk);
         if (!core_stuck && req && !req_d) begin
            req_d = 1'b1;
            ack = 1'b0;
            repeat (run_len) @(negedge clk);
            ack = 1'b1;
         end
         req_d = req;
      end
   end

   // scoreboard monitor: every req rise must match the next expected layer
   initial begin
      bit req_prev;
      logic [W-1:0] prev_cur, cur, last_e;
      req_prev = 1'b0;
      prev_cur = '0;
      last_e = '0;
      forever begin
         @(negedge clk);
         cur = observed();
         if (mon_en) begin
            if (req && !req_prev) begin
               rises++;
               if (exp_q.size() == 0) check("unexpected_req", 1, 0);
               else begin
                  last_e = exp_q.pop_front();
                  check("req_params", cur, last_e);
                  check("params_precede_req", prev_cur, last_e);
               end
            end
            if (!req && req_prev) check("params_held_to_req_fall", cur, last_e);
         end
         if (done) dones++;
         req_prev = req;
         prev_cur = cur;
      end
   end

   // driver tasks
   task automatic prog(input int addr, input layer_param_t p);
      prog_we = 1'b1;
      prog_addr = LAYERLOG'(addr);
      prog_param = p;
      model_tab[addr] = p;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic launch(input int n);
      int k;
      k = (n > MAX_LAYERS) ? MAX_LAYERS : n;
      for (int i = 0; i < k; i++) exp_q.push_back({LAYERLOG'(i), model_tab[i]});
      rises = 0;
      dones = 0;
      num_layers = (LAYERLOG+1)'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int k);
      int cyc;
      cyc = 0;
      while (dones == 0 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 2000) check("done_timeout", 0, 1);
      @(negedge clk);
      check("req_rises", rises, k);
      check("done_pulses", dones, 1);
      check("exp_q_drained", exp_q.size(), 0);
      check("idle_after_done", busy, 0);
      check("req_low_after_done", req, 0);
   endtask

   initial begin
      layer_param_t p, old0;
      int cyc, n;
      xrst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_param = '0;
      num_layers = '0; start = 1'b0;
      repeat (3) @(negedge clk);
      xrst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_req", req, 0);
      check("rst_outputs", observed(), 0);

      for (int i = 0; i < MAX_LAYERS; i++) prog(i, rand_param());

      // T1: single layer, cycle-precise launch timing
      p = '0;
      p.out_offset = 100; p.total_in = 64; p.total_out = 10; p.bias_en = 1'b1;
      prog(0, p);
      launch(1);
      check("t1_busy_T1", busy, 1);
      check("t1_req_T1", req, 0);
      @(negedge clk);
      check("t1_params_T2", observed(), {LAYERLOG'(0), p});
      check("t1_req_T2", req, 0);
      @(negedge clk);
      check("t1_req_T3", req, 1);
      wait_done(1);

      // T2: three distinct layers
      for (int i = 0; i < 3; i++) begin
         p = rand_param();
         p.in_offset = MEMSIZE'(100 * (i + 1));
         prog(i, p);
      end
      launch(3);
      wait_done(3);

      // T3: zero layers
      launch(0);
      check("t3_busy", busy, 1);
      check("t3_done_T1", done, 0);
      @(negedge clk);
      check("t3_done_T2", done, 1);
      @(negedge clk);
      check("t3_done_T3", done, 0);
      check("t3_busy_end", busy, 0);
      check("t3_no_req", rises, 0);

      // T4: core never answers
      core_stuck = 1'b1;
      launch(1);
      wait_done(1);
      check("t4_err_set", err, 1);
      core_stuck = 1'b0;
      launch(1);
      check("t4_err_cleared", err, 0);
      wait_done(1);

      // T5: start and prog_we during a run are ignored
      run_len = 4;
      old0 = model_tab[0];
      launch(3);
      cyc = 0;
      while (rises == 0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 100) check("t5_first_req_timeout", 0, 1);
      start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_param = ~old0;
      num_layers = 5'd7;
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
      wait_done(3);
      launch(1);
      wait_done(1);

      // start and prog_we together in idle: run sees the new entry
      p = rand_param();
      model_tab[0] = p;
      exp_q.push_back({LAYERLOG'(0), p});
      rises = 0; dones = 0;
      prog_we = 1'b1; prog_addr = '0; prog_param = p;
      num_layers = 5'd1; start = 1'b1;
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
      wait_done(1);

      // randomized runs including clamp beyond MAX_LAYERS
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < MAX_LAYERS; i++)
            if ($urandom_range(0, 1) == 1) prog(i, rand_param());
         run_len = $urandom_range(1, 4);
         n = (r == 0) ? 20 : $urandom_range(1, 31);
         launch(n);
         wait_done((n > MAX_LAYERS) ? MAX_LAYERS : n);
      end

      // T6: reset while the core is running a layer
      run_len = 20;
      launch(2);
      cyc = 0;
      while (ack == 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 100) check("t6_ack_timeout", 0, 1);
      @(negedge clk);
      mon_en = 1'b0;
      dones = 0;
      xrst = 1'b1;
      @(negedge clk);
      check("t6_req", req, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_err", err, 0);
      check("t6_outputs", observed(), 0);
      xrst = 1'b0;
      exp_q.delete();
      cyc = 0;
      while (ack == 1'b0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      repeat (5) @(negedge clk);
      check("t6_no_done", dones, 0);
      check("t6_req_idle", req, 0);
      mon_en = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
